acc_byte_reader: RTL

Readout unit on the accumulator's output side: on request, snapshots the 64-bit accumulator value and streams it out as bytes over a valid/ready byte interface. It lets a narrow consumer (debug UART bridge, host port) read accumulator results without stalling the datapath. The live accumulator value may change freely once the snapshot is taken.

---
 rtl/acc_pkg.sv | 13 +
 rtl/acc_byte_reader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// Shared accumulator-side definitions: word width and readout FSM state encoding.
package acc_pkg;

    localparam int ACC_DATA_W = 64;

    // CSUM keeps its code in every build so state dumps decode the same way.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } acc_rd_state_t;

endpackage

// File: rtl/acc_byte_reader.sv
// Snapshots the accumulator word and streams it out as bytes over valid/ready.
// Optional trailing XOR checksum byte when ACC_READER_CHECKSUM_EN is defined.
module acc_byte_reader
    import acc_pkg::*;
#(
    parameter int DATA_W    = ACC_DATA_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] acc_in,
    input  logic              start,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    acc_rd_state_t      state_q, state_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic               done_q, done_d;
`ifdef ACC_READER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic [IDX_W-1:0]   sel;
    logic [7:0]         cur_byte;
    logic               last_idx;
    logic               hs;

    always_comb begin
        sel = MSB_FIRST ? (IDX_W'(NBYTES - 1) - byte_idx_q) : byte_idx_q;
        cur_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel == IDX_W'(i)) cur_byte = shadow_q[i*8 +: 8];
        end
    end

    assign last_idx = (byte_idx_q == IDX_W'(NBYTES - 1));
    assign busy     = (state_q != IDLE);
    assign tx_valid = busy;
    assign hs       = tx_valid && tx_ready;
    assign done     = done_q;

    always_comb begin
        tx_data = 8'h00;
        tx_last = 1'b0;
        if (state_q == SEND) begin
            tx_data = cur_byte;
`ifndef ACC_READER_CHECKSUM_EN
            tx_last = last_idx;
`endif
        end
`ifdef ACC_READER_CHECKSUM_EN
        else if (state_q == CSUM) begin
            tx_data = csum_q;
            tx_last = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
`ifdef ACC_READER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d   = acc_in;
                    byte_idx_d = '0;
                    state_d    = SEND;
`ifdef ACC_READER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            SEND: begin
                if (hs) begin
`ifdef ACC_READER_CHECKSUM_EN
                    csum_d = csum_q ^ cur_byte;
`endif
                    if (last_idx) begin
                        byte_idx_d = '0;
`ifdef ACC_READER_CHECKSUM_EN
                        state_d    = CSUM;
`else
                        state_d    = IDLE;
                        done_d     = 1'b1;
`endif
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef ACC_READER_CHECKSUM_EN
            CSUM: begin
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            byte_idx_q <= '0;
            done_q     <= 1'b0;
`ifdef ACC_READER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
`ifdef ACC_READER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule
